soc_mem_loader: RTL and testbench
=================================

SOC_MEM_LOADER -- requirements
Module: soc_mem_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, memory word width; a multiple of 8 and at least 8; BYTES = DATA_WIDTH/8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 12, word-address width of each target memory.
REQ-003 SHALL have parameter NUM_MEM, default 2, number of target memories (0 = imem, 1 = dmem); range 1..256.
REQ-004 SHALL have clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have load_en  input  1  level; loader session active while high.
REQ-007 SHALL have byte_valid  input  1  source has a byte on byte_data.
REQ-008 SHALL have byte_data  input  8  stream byte.
REQ-009 SHALL have byte_ready  output  1  loader accepts a byte; transfer occurs when byte_valid and byte_ready are both high on a rising edge.
REQ-010 SHALL have mem_wr_en  output  NUM_MEM  one-hot, one-cycle write strobe per target memory.
REQ-011 SHALL have mem_addr  output  ADDR_WIDTH  word address for the write.
REQ-012 SHALL have mem_wdata  output  DATA_WIDTH  write data.
REQ-013 SHALL have busy, done, error  output  1 each  session status flags.

Function
REQ-014 SHALL implement states IDLE, HDR_SEL, HDR_CNT0, HDR_CNT1, DATA, DONE, ERROR.
REQ-015 SHALL transition IDLE -> HDR_SEL when load_en is high; all other states -> IDLE on the first edge where load_en is low (abort).
REQ-016 SHALL drive byte_ready high only in HDR_SEL, HDR_CNT0, HDR_CNT1 and DATA, and low in IDLE, DONE, ERROR and while load_en is low.
REQ-017 SHALL, in HDR_SEL, latch the accepted byte as target index; an index >= NUM_MEM SHALL go to ERROR, otherwise to HDR_CNT0.
REQ-018 SHALL, in HDR_CNT0/HDR_CNT1, latch a 16-bit word count N, low byte first.
REQ-019 SHALL go HDR_CNT1 -> DONE if N == 0, else -> DATA.
REQ-020 SHALL, in DATA, assemble BYTES accepted bytes little-endian: first byte -> bits [7:0], last byte -> top byte.
REQ-021 SHALL, on acceptance of the final byte of a word, on the next cycle pulse mem_wr_en[target] high for exactly one cycle with mem_wdata = the assembled word and mem_addr = the current word address.
REQ-022 SHALL keep byte_ready high during the write cycle, sustaining one byte per cycle with no stall.
REQ-023 SHALL start the word address at 0 for each session, increment it by 1 after each write, and wrap modulo 2^ADDR_WIDTH.
REQ-024 SHALL enter DONE after the Nth word is written, so that DONE coincides with the cycle after the last write strobe.
REQ-025 SHALL stay in DONE or ERROR until load_en goes low.
REQ-026 SHALL drive busy high in HDR_* and DATA, and during a pending write strobe.
REQ-027 SHALL drive done high only in DONE and error high only in ERROR.
REQ-028 SHALL, on abort, discard any partial word, issue no further strobes, and complete any strobe already registered.
REQ-029 SHALL drive mem_wr_en to all zeros whenever no write is due; mem_addr and mem_wdata SHALL be held otherwise.

Reset
REQ-030 SHALL, while reset is high, force state IDLE, mem_wr_en = 0, mem_addr = 0, mem_wdata = 0, byte_ready = 0, busy = 0, done = 0, error = 0, and clear the byte and word counters.
REQ-031 SHALL, when reset is asserted mid-session, take effect immediately; no strobe SHALL occur and the source SHALL be left to restart the header after load_en is seen.

Verification
REQ-032 SHALL pass: defaults, load_en = 1, bytes 00 02 00 EF BE AD DE 78 56 34 12 streamed back-to-back -> mem_wr_en = 01 strobes at addr 0 (data DEADBEEF) and addr 1 (data 12345678), then done = 1.
REQ-033 SHALL pass: header 01 00 00 -> no strobes, done = 1 one cycle after the count high byte.
REQ-034 SHALL pass: header 05 -> error = 1, byte_ready = 0; load_en low -> IDLE, error = 0.
REQ-035 SHALL pass: ADDR_WIDTH = 2, N = 5, dmem -> addresses 0, 1, 2, 3, 0 in order.
REQ-036 SHALL pass: load_en dropped after 2 data bytes -> no strobe; a new session writes from addr 0.
REQ-037 SHALL pass: random byte_valid gaps with DATA_WIDTH = 64 -> words identical to the gap-free run.

Source files
------------

// File: rtl/soc_mem_loader.sv
// Streams a byte-oriented image (target index, 16-bit word count, data) into one of
// NUM_MEM word memories, assembling little-endian words and issuing one-cycle write strobes.
//
// state    | meaning
// IDLE     | no session; waiting for load_en
// HDR_SEL  | expecting target memory index byte
// HDR_CNT0 | expecting word count low byte
// HDR_CNT1 | expecting word count high byte
// DATA     | assembling words; leaves once the last word strobe is issued
// DONE     | session complete, waiting for load_en low
// ERROR    | bad target index, waiting for load_en low
module soc_mem_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int NUM_MEM    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_en,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic [NUM_MEM-1:0]    mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [BW-1:0] LAST_BYTE = BW'(BYTES - 1);

    typedef enum logic [2:0] {
        IDLE, HDR_SEL, HDR_CNT0, HDR_CNT1, DATA, DONE, ERROR
    } state_t;

    state_t                  state_q, state_d;
    logic [7:0]              target_q;
    logic [7:0]              cnt_lo_q;
    logic [15:0]             words_left_q;
    logic [BW-1:0]           byte_idx_q;
    logic [ADDR_WIDTH-1:0]   addr_cnt_q;
    logic [DATA_WIDTH-1:0]   word_buf_q;
    logic [DATA_WIDTH-1:0]   word_next;
    logic                    active;
    logic                    accept;
    logic                    data_ok;
    logic                    word_last;

    always_comb begin
        active     = (state_q == HDR_SEL) || (state_q == HDR_CNT0) ||
                     (state_q == HDR_CNT1) || (state_q == DATA);
        byte_ready = load_en && active;
        accept     = byte_valid && byte_ready;
        // Once the last word is counted, DATA lingers one cycle for its strobe; bytes then are dropped.
        data_ok    = (state_q == DATA) && (words_left_q != 16'd0);
        word_last  = accept && data_ok && (byte_idx_q == LAST_BYTE);
        word_next  = word_buf_q;
        word_next[8*byte_idx_q +: 8] = byte_data;
        busy       = active || (|mem_wr_en);
        done       = (state_q == DONE);
        error      = (state_q == ERROR);
    end

    always_comb begin
        state_d = state_q;
        if (state_q != IDLE && !load_en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:     if (load_en) state_d = HDR_SEL;
                HDR_SEL:  if (accept) state_d = (int'(byte_data) >= NUM_MEM) ? ERROR : HDR_CNT0;
                HDR_CNT0: if (accept) state_d = HDR_CNT1;
                HDR_CNT1: if (accept) state_d = ({byte_data, cnt_lo_q} == 16'd0) ? DONE : DATA;
                DATA:     if (words_left_q == 16'd0) state_d = DONE;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            target_q     <= '0;
            cnt_lo_q     <= '0;
            words_left_q <= '0;
            byte_idx_q   <= '0;
            addr_cnt_q   <= '0;
            word_buf_q   <= '0;
            mem_wr_en    <= '0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
        end else begin
            state_q   <= state_d;
            mem_wr_en <= '0;
            if (state_q == IDLE) begin
                byte_idx_q <= '0;
                addr_cnt_q <= '0;
            end
            if (accept) begin
                case (state_q)
                    HDR_SEL:  target_q     <= byte_data;
                    HDR_CNT0: cnt_lo_q     <= byte_data;
                    HDR_CNT1: words_left_q <= {byte_data, cnt_lo_q};
                    default:  ;
                endcase
            end
            if (accept && data_ok) begin
                word_buf_q <= word_next;
                byte_idx_q <= word_last ? '0 : byte_idx_q + BW'(1);
                if (word_last) begin
                    mem_wr_en    <= NUM_MEM'(1) << target_q;
                    mem_addr     <= addr_cnt_q;
                    mem_wdata    <= word_next;
                    addr_cnt_q   <= addr_cnt_q + ADDR_WIDTH'(1);
                    words_left_q <= words_left_q - 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_soc_mem_loader.sv
// Bench for soc_mem_loader: a default instance (32-bit words) and a 64-bit / 2-bit-address
// instance, driven by table-driven sessions plus hand-written timing and abort sequences.
module tb_soc_mem_loader;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        a_en, a_valid, a_ready, a_busy, a_done, a_err;
    logic [7:0]  a_data;
    logic [1:0]  a_wr;
    logic [11:0] a_addr;
    logic [31:0] a_wdata;

    logic        b_en, b_valid, b_ready, b_busy, b_done, b_err;
    logic [7:0]  b_data;
    logic [1:0]  b_wr;
    logic [1:0]  b_addr;
    logic [63:0] b_wdata;

    soc_mem_loader u_a (
        .clk(clk), .reset(reset), .load_en(a_en), .byte_valid(a_valid), .byte_data(a_data),
        .byte_ready(a_ready), .mem_wr_en(a_wr), .mem_addr(a_addr), .mem_wdata(a_wdata),
        .busy(a_busy), .done(a_done), .error(a_err)
    );

    soc_mem_loader #(.DATA_WIDTH(64), .ADDR_WIDTH(2), .NUM_MEM(2)) u_b (
        .clk(clk), .reset(reset), .load_en(b_en), .byte_valid(b_valid), .byte_data(b_data),
        .byte_ready(b_ready), .mem_wr_en(b_wr), .mem_addr(b_addr), .mem_wdata(b_wdata),
        .busy(b_busy), .done(b_done), .error(b_err)
    );

    typedef struct packed {
        logic [1:0]  en;
        logic [11:0] addr;
        logic [63:0] data;
    } wr_t;

    wr_t qa[$], qb[$], qexp[$], qsave[$];
    int  errors = 0;
    int  checks = 0;

    always @(negedge clk) begin
        if (a_wr != 2'b00) qa.push_back('{a_wr, a_addr, {32'b0, a_wdata}});
        if (b_wr != 2'b00) qb.push_back('{b_wr, {10'b0, b_addr}, b_wdata});
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic rdy_f(input bit sel);  return sel ? b_ready : a_ready; endfunction
    function automatic logic done_f(input bit sel); return sel ? b_done  : a_done;  endfunction
    function automatic logic err_f(input bit sel);  return sel ? b_err   : a_err;   endfunction
    function automatic logic busy_f(input bit sel); return sel ? b_busy  : a_busy;  endfunction

    task automatic drive(input bit sel, input logic v, input logic [7:0] d);
        if (sel) begin b_valid = v; b_data = d; end
        else     begin a_valid = v; a_data = d; end
    endtask

    task automatic set_en(input bit sel, input logic v);
        if (sel) b_en = v; else a_en = v;
    endtask

    // Called on a negedge; returns on the negedge right after the byte is transferred.
    task automatic send(input bit sel, input logic [7:0] b, input int gap);
        int n = 0;
        repeat (gap) @(negedge clk);
        drive(sel, 1'b1, b);
        while (!rdy_f(sel) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: byte_ready stayed low, want high");
        end
        @(posedge clk);
        @(negedge clk);
        drive(sel, 1'b0, 8'h00);
    endtask

    task automatic cmp_writes(input bit sel, input string tag);
        wr_t q[$];
        if (sel) q = qb; else q = qa;
        chk({tag, " nwrites"}, 64'(q.size()), 64'(qexp.size()));
        for (int i = 0; i < q.size() && i < qexp.size(); i++) begin
            chk({tag, " en"},   64'(q[i].en),   64'(qexp[i].en));
            chk({tag, " addr"}, 64'(q[i].addr), 64'(qexp[i].addr));
            chk({tag, " data"}, q[i].data,      qexp[i].data);
        end
    endtask

    // Full session with model: target, N words, bytes derived from seed, random gaps up to maxgap.
    task automatic session(input bit sel, input int tgt, input int n, input int maxgap,
                           input int seed, input bit exp_done, input bit exp_err,
                           input string tag);
        int          bpw = sel ? 8 : 4;
        int          aw  = sel ? 2 : 12;
        int          idx = 0;
        logic [63:0] w;
        logic [7:0]  b;
        qexp.delete();
        if (sel) qb.delete(); else qa.delete();
        set_en(sel, 1'b1);
        @(negedge clk);
        send(sel, tgt[7:0], 0);
        if (!exp_err) begin
            send(sel, n[7:0], $urandom_range(0, maxgap));
            send(sel, n[15:8], $urandom_range(0, maxgap));
            for (int wi = 0; wi < n; wi++) begin
                w = '0;
                for (int k = 0; k < bpw; k++) begin
                    b = 8'(seed + idx * 37 + (idx >> 2));
                    idx++;
                    w[8*k +: 8] = b;
                    send(sel, b, $urandom_range(0, maxgap));
                end
                qexp.push_back('{2'(1 << tgt), 12'(wi % (1 << aw)), w});
            end
        end
        repeat (2) @(negedge clk);
        chk({tag, " done"},  64'(done_f(sel)), 64'(exp_done));
        chk({tag, " error"}, 64'(err_f(sel)),  64'(exp_err));
        chk({tag, " ready"}, 64'(rdy_f(sel)),  64'(0));
        chk({tag, " busy"},  64'(busy_f(sel)), 64'(0));
        cmp_writes(sel, tag);
        set_en(sel, 1'b0);
        repeat (2) @(negedge clk);
        chk({tag, " idle_done"},  64'(done_f(sel)), 64'(0));
        chk({tag, " idle_error"}, 64'(err_f(sel)),  64'(0));
    endtask

    typedef struct {
        bit sel;
        int tgt;
        int n;
        int maxgap;
        bit exp_done;
        bit exp_err;
    } vec_t;

    vec_t vt[9];

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not finish, want finish");
        $fatal(1);
    end

    initial begin
        vt = '{
            '{0, 0,   3, 0, 1, 0},
            '{0, 1,   2, 3, 1, 0},
            '{0, 1,   0, 0, 1, 0},
            '{0, 5,   0, 0, 0, 1},
            '{1, 1,   5, 0, 1, 0},
            '{1, 0,   4, 4, 1, 0},
            '{0, 2,   0, 0, 0, 1},
            '{1, 255, 0, 0, 0, 1},
            '{0, 0,   6, 2, 1, 0}
        };
        reset = 1'b1;
        a_en = 0; a_valid = 0; a_data = 0;
        b_en = 0; b_valid = 0; b_data = 0;
        repeat (2) @(negedge clk);
        chk("rst a_ready", 64'(a_ready), 0);
        chk("rst a_wr",    64'(a_wr),    0);
        chk("rst a_addr",  64'(a_addr),  0);
        chk("rst a_wdata", 64'(a_wdata), 0);
        chk("rst a_flags", 64'({a_busy, a_done, a_err}), 0);
        chk("rst b_flags", 64'({b_ready, b_busy, b_done, b_err, b_wr}), 0);
        reset = 1'b0;
        @(negedge clk);

        // Reference stream with strobe timing
        qa.delete();
        a_en = 1'b1;
        @(negedge clk);
        send(0, 8'h00, 0); send(0, 8'h02, 0); send(0, 8'h00, 0);
        send(0, 8'hEF, 0); send(0, 8'hBE, 0); send(0, 8'hAD, 0); send(0, 8'hDE, 0);
        chk("ref w0 en",    64'(a_wr),    64'h1);
        chk("ref w0 addr",  64'(a_addr),  64'h0);
        chk("ref w0 data",  64'(a_wdata), 64'hDEADBEEF);
        chk("ref w0 busy",  64'(a_busy),  64'h1);
        chk("ref w0 ready", 64'(a_ready), 64'h1);
        send(0, 8'h78, 0); send(0, 8'h56, 0); send(0, 8'h34, 0); send(0, 8'h12, 0);
        chk("ref w1 en",    64'(a_wr),    64'h1);
        chk("ref w1 addr",  64'(a_addr),  64'h1);
        chk("ref w1 data",  64'(a_wdata), 64'h12345678);
        chk("ref w1 done",  64'(a_done),  64'h0);
        @(negedge clk);
        chk("ref end en",    64'(a_wr),    64'h0);
        chk("ref end done",  64'(a_done),  64'h1);
        chk("ref end ready", 64'(a_ready), 64'h0);
        chk("ref nwrites",   64'(qa.size()), 64'd2);
        a_en = 1'b0;
        repeat (2) @(negedge clk);

        // Empty image: done the cycle after the count high byte
        qa.delete();
        a_en = 1'b1;
        @(negedge clk);
        send(0, 8'h01, 0); send(0, 8'h00, 0); send(0, 8'h00, 0);
        chk("n0 done", 64'(a_done), 64'h1);
        @(negedge clk);
        chk("n0 nwrites", 64'(qa.size()), 64'd0);
        a_en = 1'b0;
        repeat (2) @(negedge clk);

        // Abort mid-word: nothing written, next session restarts at address 0
        qa.delete();
        a_en = 1'b1;
        @(negedge clk);
        send(0, 8'h00, 0); send(0, 8'h02, 0); send(0, 8'h00, 0);
        send(0, 8'hAA, 0); send(0, 8'hBB, 0);
        a_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort nwrites", 64'(qa.size()), 64'd0);
        chk("abort busy",    64'(a_busy),    64'd0);
        session(0, 0, 1, 0, 8'h5A, 1, 0, "after_abort");

        // Abort with a strobe already registered: it completes, nothing follows
        qa.delete();
        a_en = 1'b1;
        @(negedge clk);
        send(0, 8'h01, 0); send(0, 8'h02, 0); send(0, 8'h00, 0);
        send(0, 8'h11, 0); send(0, 8'h22, 0); send(0, 8'h33, 0); send(0, 8'h44, 0);
        a_en = 1'b0;
        send(0, 8'h55, 0);
        repeat (3) @(negedge clk);
        chk("abort_pend nwrites", 64'(qa.size()), 64'd1);
        if (qa.size() > 0) chk("abort_pend data", qa[0].data, 64'h44332211);
        if (qa.size() > 0) chk("abort_pend en", 64'(qa[0].en), 64'h2);

        // Reset mid-session, then the source restarts the header
        qa.delete();
        a_en = 1'b1;
        @(negedge clk);
        send(0, 8'h00, 0); send(0, 8'h01, 0); send(0, 8'h00, 0);
        send(0, 8'h99, 0); send(0, 8'h98, 0); send(0, 8'h97, 0);
        reset = 1'b1;
        #1;
        chk("midrst ready", 64'(a_ready), 64'h0);
        chk("midrst busy",  64'(a_busy),  64'h0);
        @(negedge clk);
        reset = 1'b0;
        send(0, 8'h00, 0); send(0, 8'h01, 0); send(0, 8'h00, 0);
        send(0, 8'h11, 0); send(0, 8'h22, 0); send(0, 8'h33, 0); send(0, 8'h44, 0);
        repeat (2) @(negedge clk);
        chk("midrst nwrites", 64'(qa.size()), 64'd1);
        if (qa.size() > 0) chk("midrst addr", 64'(qa[0].addr), 64'h0);
        if (qa.size() > 0) chk("midrst data", qa[0].data, 64'h44332211);
        a_en = 1'b0;
        repeat (2) @(negedge clk);

        // Table-driven sessions against the reference model
        for (int i = 0; i < 9; i++) begin
            session(vt[i].sel, vt[i].tgt, vt[i].n, vt[i].maxgap, int'($urandom_range(0, 255)),
                    vt[i].exp_done, vt[i].exp_err, $sformatf("vec%0d", i));
        end

        // 64-bit words: gapped run must match the gap-free run of the same bytes
        session(1, 1, 6, 0, 8'h3C, 1, 0, "gapfree");
        qsave = qb;
        session(1, 1, 6, 5, 8'h3C, 1, 0, "gapped");
        chk("gap nwrites", 64'(qb.size()), 64'(qsave.size()));
        for (int i = 0; i < qb.size() && i < qsave.size(); i++) begin
            chk("gap word", qb[i].data, qsave[i].data);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
